// File: rtl/mem_ser_pkg.sv
// Shared types and helpers for the byte-serialised word memory (mem_ser).
package mem_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  // Word lane (in bytes, 0 = least significant) that serial byte k maps to.
  // Big-endian puts the most significant byte at the lowest address.
  function automatic int byte_lane(input int k, input int word_bytes, input bit big_endian);
    return big_endian ? (word_bytes - 1 - k) : k;
  endfunction

endpackage

// File: rtl/mem_ser_bytes.sv
// Byte-organised storage for mem_ser: one write port, one registered read port.
// WIDTH is 8, or 9 when the parity option (MEM_SER_PARITY_EN) is built in.
module mem_ser_bytes #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  q
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; a write edge that coincides with reset is suppressed.
  // NOTE: the array has no reset branch so it maps onto RAM and keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (we && rst) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its last value when no read is requested.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem_ser.sv
// mem_ser: writes a full word into byte storage one byte per cycle and reads it
// back serially while reassembling the word. Optional even-parity protection of
// each stored byte is enabled by defining MEM_SER_PARITY_EN.
module mem_ser
  import mem_ser_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [8*WORD_BYTES-1:0] datain,
  output logic [7:0]              dataout,
  output logic                    dout_valid,
  output logic [8*WORD_BYTES-1:0] rdata,
  output logic                    rdata_valid,
  output logic                    busy,
  output logic                    par_err
);

  localparam int K_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam bit BE  = (BIG_ENDIAN != 0);
`ifdef MEM_SER_PARITY_EN
  localparam int MEM_W = 9;
`else
  localparam int MEM_W = 8;
`endif

  state_t                  state, state_nxt;
  logic [K_W-1:0]          k;
  logic [K_W-1:0]          rd_lane_q;
  logic [ADDR_W-1:0]       base;
  logic [8*WORD_BYTES-1:0] word_q;
  logic [8*WORD_BYTES-1:0] asm_q;
  logic [8*WORD_BYTES-1:0] rdata_q;
  logic [8*WORD_BYTES-1:0] rdata_full;
  logic                    last;
  logic [ADDR_W-1:0]       mem_addr;
  logic [7:0]              wr_byte;
  logic [MEM_W-1:0]        mem_wdata;
  logic [MEM_W-1:0]        mem_q;

  assign last     = (k == K_W'(WORD_BYTES - 1));
  assign mem_addr = base + ADDR_W'(k);
  assign busy     = (state != IDLE);
  assign wr_byte  = word_q[8*byte_lane(int'(k), WORD_BYTES, BE) +: 8];
  assign dataout  = mem_q[7:0];

`ifdef MEM_SER_PARITY_EN
  // Stored bit 8 makes each 9-bit entry even parity; any odd result is an error.
  assign mem_wdata = {^wr_byte, wr_byte};
  assign par_err   = dout_valid & (^mem_q);
`else
  assign mem_wdata = wr_byte;
  assign par_err   = 1'b0;
`endif

  // Next-state logic: write wins over read; requests outside IDLE are dropped.
  // NOTE: the default is assigned first so every path drives state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr) state_nxt = WRITE;
               else if (rd) state_nxt = READ;
      WRITE,
      READ:    if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, byte counter and read-side strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      rd_lane_q   <= '0;
      dout_valid  <= 1'b0;
      rdata_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      dout_valid  <= (state == READ);
      rdata_valid <= (state == READ) && last;
      rd_lane_q   <= K_W'(byte_lane(int'(k), WORD_BYTES, BE));
      if (state == IDLE) begin
        k <= '0;
      end else if (!last) begin
        k <= k + K_W'(1);
      end
    end
  end

  // Request capture: start address for both directions, word only for writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      base   <= '0;
      word_q <= '0;
    end else if (state == IDLE) begin
      if (wr || rd) base <= addr;
      if (wr) word_q <= datain;
    end
  end

  // Current word: earlier bytes of this read with the byte now on dataout overlaid.
  always_comb begin
    rdata_full = asm_q;
    rdata_full[8*int'(rd_lane_q) +: 8] = dataout;
  end

  // Word assembly; the completed word is held until the next read finishes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (dout_valid) asm_q <= rdata_full;
      if (rdata_valid) rdata_q <= rdata_full;
    end
  end

  assign rdata = rdata_valid ? rdata_full : rdata_q;

  mem_ser_bytes #(
    .ADDR_W (ADDR_W),
    .WIDTH  (MEM_W)
  ) u_bytes (
    .clk   (clk),
    .rst   (rst),
    .we    (state == WRITE),
    .waddr (mem_addr),
    .wdata (mem_wdata),
    .re    (state == READ),
    .raddr (mem_addr),
    .q     (mem_q)
  );

endmodule

// File: tb/tb_mem_ser.sv
// Self-checking bench for mem_ser with default parameters (16 bytes, 4-byte
// words, big-endian). The parity check runs only when MEM_SER_PARITY_EN is set.
module tb_mem_ser;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic        rd;
  logic [3:0]  addr;
  logic [31:0] datain;
  logic [7:0]  dataout;
  logic        dout_valid;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        par_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference image of the 16-byte storage, in address order.
  logic [7:0] m [16];

  typedef struct {
    bit          is_wr;
    logic [3:0]  a;
    logic [31:0] word;   // write data, or expected read word
  } vec_t;

  vec_t vecs [8];

  mem_ser dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .rd          (rd),
    .addr        (addr),
    .datain      (datain),
    .dataout     (dataout),
    .dout_valid  (dout_valid),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .par_err     (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int a);
    logic [31:0] w = '0;
    for (int j = 0; j < 4; j++) w = {w[23:0], m[(a + j) % 16]};
    return w;
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input bit also_rd);
    int cnt = 0;
    wr = 1'b1; rd = also_rd; addr = a; datain = d;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    while (busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("write_busy_cycles", 32'(cnt), 32'd4);
    for (int j = 0; j < 4; j++) m[(int'(a) + j) % 16] = d[8*(3-j) +: 8];
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input int bad_j);
    int j = 0;
    int pulses = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    rd = 1'b1; addr = a;
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0;
    for (int cyc = 0; cyc < 12 && j < 4; cyc++) begin
      @(negedge clk);
      if (rdata_valid) pulses++;
      if (dout_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        check("read_byte", 32'(dataout), 32'(exp[8*(3-j) +: 8]));
        check("read_par_err", 32'(par_err), 32'(j == bad_j));
        check("read_rdata_valid", 32'(rdata_valid), 32'(j == 3));
        if (j == 3) check("read_rdata_word", rdata, exp);
        j++;
      end
    end
    check("read_byte_count", 32'(j), 32'd4);
    check("read_dout_consecutive", 32'(last_cyc - first_cyc), 32'd3);
    check("read_valid_pulses", 32'(pulses), 32'd1);
    @(negedge clk);
    check("read_after_busy", 32'(busy), 32'd0);
    check("read_after_rvalid", 32'(rdata_valid), 32'd0);
    check("read_rdata_held", rdata, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr = 1'b0; rd = 1'b0; addr = '0; datain = '0; rst = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors, including wrap past the top address.
    vecs[0] = '{1'b1, 4'd0,  32'hA1B2C3D4};
    vecs[1] = '{1'b0, 4'd0,  32'hA1B2C3D4};
    vecs[2] = '{1'b0, 4'd2,  32'hC3D40000 | 32'(m[4]) << 8 | 32'(m[5])};
    vecs[3] = '{1'b1, 4'd14, 32'h11223344};
    vecs[4] = '{1'b0, 4'd14, 32'h11223344};
    vecs[5] = '{1'b0, 4'd0,  32'h3344C3D4};
    vecs[6] = '{1'b0, 4'd15, 32'h223344C3};
    vecs[7] = '{1'b0, 4'd1,  32'h44C3D400 | 32'(m[4])};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].word, 1'b0);
      else do_read(vecs[i].a, vecs[i].word, -1);
    end

    // Fill every byte so the model is fully known, then random traffic.
    for (int i = 0; i < 16; i += 4) do_write(4'(i), $urandom, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 1'b0);
      else do_read(a, model_word(int'(a)), -1);
    end

    // Write request while a read is busy is ignored; wr+rd together in IDLE writes.
    begin
      logic [31:0] exp8;
      exp8 = model_word(8);
      rd = 1'b1; addr = 4'd0;
      @(posedge clk);
      @(negedge clk);
      rd = 1'b0;
      wr = 1'b1; addr = 4'd8; datain = 32'hFFFFFFFF;
      repeat (2) @(negedge clk);
      wr = 1'b0;
      for (int c = 0; c < 10 && busy; c++) @(negedge clk);
      check("busy_drop_after_read", 32'(busy), 32'd0);
      do_write(4'd4, 32'h55667788, 1'b1);
      do_read(4'd8, exp8, -1);
      do_read(4'd4, 32'h55667788, -1);
    end

    // Back-to-back: read accepted on the first edge after busy falls.
    do_write(4'd10, 32'h0BADF00D, 1'b0);
    do_read(4'd10, 32'h0BADF00D, -1);

    // Reset after the second write byte: first two bytes new, rest old.
    do_write(4'd0, 32'hA1B2C3D4, 1'b0);
    wr = 1'b1; addr = 4'd0; datain = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midwrite_rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    m[0] = 8'hDE; m[1] = 8'hAD;
    @(negedge clk);
    do_read(4'd0, 32'hDEADC3D4, -1);

    // Reset mid-read drops the read and clears the read outputs.
    begin
      int pulses = 0;
      rd = 1'b1; addr = 4'd0;
      @(posedge clk);
      @(negedge clk);
      rd = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midread_rst_busy", 32'(busy), 32'd0);
      check("midread_rst_dout_valid", 32'(dout_valid), 32'd0);
      check("midread_rst_dataout", 32'(dataout), 32'd0);
      check("midread_rst_rdata", rdata, 32'd0);
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (rdata_valid) pulses++;
      end
      check("midread_no_rdata_valid", 32'(pulses), 32'd0);
    end

`ifdef MEM_SER_PARITY_EN
    // Corrupt the stored parity of byte 2; only the third serial byte flags.
    do_write(4'd0, 32'hA1B2C3D4, 1'b0);
    dut.u_bytes.mem[2] = dut.u_bytes.mem[2] ^ 9'h100;
    do_read(4'd0, 32'hA1B2C3D4, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ser.md
# mem_ser

Parametrised byte-serialised word memory and the successor to the fixed 32-bit, 16-byte serial memory. It accepts a full word and writes it one byte per cycle into byte-addressed storage. On reads it returns the word one byte per cycle and also presents the reassembled word. It sits between word-wide register/bus logic and byte-organised storage; `busy` is the only flow control.

## Interface
- `ADDR_W`, 4: byte address width; DEPTH = 2**ADDR_W bytes.
- `WORD_BYTES`, 4: bytes per word transfer, ≥1, ≤ DEPTH.
- `BIG_ENDIAN`, 1: 1 = most significant byte at lowest address; 0 = least significant byte at lowest address.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `wr`  in  1  write request, sampled only in IDLE.
- `rd`  in  1  read request, sampled only in IDLE.
- `addr`  in  ADDR_W  start byte address; need not be word-aligned.
- `datain`  in  8*WORD_BYTES  write word.
- `dataout`  out  8  serial read byte.
- `dout_valid`  out  1  `dataout` holds a read byte this cycle.
- `rdata`  out  8*WORD_BYTES  assembled read word.
- `rdata_valid`  out  1  one-cycle pulse; `rdata` complete.
- `busy`  out  1  high while in WRITE or READ.
- `par_err`  out  1  parity mismatch on the current `dataout` byte; tied 0 without the macro.

## Operation
- FSM states: IDLE, WRITE, READ. `busy` = (state != IDLE).
- In IDLE, on an edge with `wr`=1: latch `addr` and `datain`, clear byte counter `k`, go to WRITE. `wr` wins if `wr` and `rd` are both high.
- In IDLE, on an edge with `rd`=1 and `wr`=0: latch `addr`, clear `k`, go to READ.
- Requests in WRITE/READ are ignored. There is no queue; the requester must re-present the request after `busy` falls.
- WRITE: each edge stores byte `k` at mem[(addr+k) mod DEPTH], then `k`++. After byte WORD_BYTES-1 the FSM returns to IDLE.
- Byte k source: `BIG_ENDIAN`=1 uses datain[8*(WORD_BYTES-1-k) +: 8]; `BIG_ENDIAN`=0 uses datain[8*k +: 8].
- READ: each edge registers mem[(addr+k) mod DEPTH] into `dataout`, sets `dout_valid`, and shifts the byte into `rdata` at the lane given by the same endian rule. On the last byte `rdata_valid` is set and the FSM returns to IDLE.
- Addresses wrap modulo DEPTH; there is no out-of-range error.
- `rdata` holds its value until the next read completes. `dataout` holds its last byte when `dout_valid`=0.

## Timing
- Accept edge E0. Write bytes land at E1..E_WORD_BYTES. `busy` is high for exactly WORD_BYTES cycles, starting the cycle after E0.
- For reads, `dout_valid` is high for WORD_BYTES consecutive cycles after E1..E_WORD_BYTES. `rdata_valid` is high only in the cycle after E_WORD_BYTES, coincident with the last `dout_valid`.
- A new request can be accepted on the first edge where `busy`=0 (back-to-back gap: 0 idle cycles).
- A read of a byte written by a completed write returns the new value; a read cannot overlap a write.
- Reset (`rst`=0 at an edge):
  - State goes to IDLE; `busy`, `dout_valid`, `rdata_valid` and `par_err` go to 0; `dataout`, `rdata` and `k` go to 0.
  - Storage is not cleared.
  - Reset mid-write leaves bytes already written updated and the remaining bytes unchanged.
  - Reset mid-read drops the read with no `rdata_valid`.

## Configuration
- `MEM_SER_PARITY_EN` defined: each byte is stored with an even-parity bit computed on write. On read, `par_err` is high with `dout_valid` when the stored parity does not match the byte.
- `MEM_SER_PARITY_EN` undefined: storage is 8 bits per byte, and `par_err` is constant 0.

## Structure
- Package `mem_ser_pkg`: FSM state enum (IDLE/WRITE/READ) and the byte-lane index function used for the endian rule.
- Sub-module `mem_ser_bytes`: the DEPTH×8 storage array (×9 with parity), with one write port and one registered read port. The parent holds the FSM, counter and word assembly.

## Test plan
- Write 0xA1B2C3D4 at addr 0 (defaults) -> mem[0..3] = A1,B2,C3,D4; `busy` high exactly 4 cycles.
- Read addr 0 -> `dataout` A1,B2,C3,D4 on 4 consecutive `dout_valid` cycles; `rdata`=0xA1B2C3D4 with `rdata_valid` on the 4th.
- Write 0x11223344 at addr 14 -> mem[14]=11, mem[15]=22, mem[0]=33, mem[1]=44; read addr 14 returns 0x11223344.
- `wr` to addr 8 with 0xFFFFFFFF during a busy read, plus `wr`+`rd` together in IDLE with addr 4 and data 0x55667788 -> first request is ignored (mem[8] unchanged); second performs the write (mem[4..7] = 55,66,77,88).
- `rst`=0 after the 2nd write byte of 0xDEADBEEF to addr 0 over 0xA1B2C3D4 -> `busy` 0 the next cycle; mem[0..3] = DE,AD,C3,D4.
- `MEM_SER_PARITY_EN` defined: force a stored bit flip in mem[2], then read addr 0 -> `par_err`=1 only on the 3rd `dout_valid` cycle.
